// File: rtl/pc_trace_buffer.sv
// On-chip PC/aux trace buffer: arms, optionally waits for a trigger PC, records
// samples in a circular or stop-on-full store, and detects a PC self-loop as halt.
module pc_trace_buffer #(
  parameter int PC_W     = 32,
  parameter int AUX_W    = 32,
  parameter int DEPTH    = 16,
  parameter int HALT_CYC = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     arm_i,
  input  logic                     stop_i,
  input  logic                     mode_i,
  input  logic                     trig_en_i,
  input  logic [PC_W-1:0]          trig_pc_i,
  input  logic                     pc_valid_i,
  input  logic [PC_W-1:0]          pc_i,
  input  logic [AUX_W-1:0]         aux_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
  output logic                     rd_valid_o,
  output logic [PC_W-1:0]          rd_pc_o,
  output logic [AUX_W-1:0]         rd_aux_o,
  output logic [1:0]               state_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     wrapped_o,
  output logic                     halted_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(HALT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state;
  logic [AW-1:0]     wr_ptr;
  logic [RW-1:0]     rep_cnt;
  logic              mode_q;
  logic              trig_en_q;
  logic [PC_W-1:0]   trig_pc_q;
  logic [PC_W-1:0]   last_pc;

  logic [PC_W-1:0]   mem_pc  [DEPTH];
  logic [AUX_W-1:0]  mem_aux [DEPTH];

  logic              trig_ok;
  logic              take;
  logic              is_repeat;
  logic              wr_en;
  logic              rd_hit;
  logic [AW-1:0]     rd_addr;

  assign state_o = state;

  // NOTE: every signal gets a value before any condition, so no latch is inferred.
  always_comb begin
    trig_ok   = !trig_en_q || (pc_i == trig_pc_q);
    take      = 1'b0;
    if (rst_i && pc_valid_i && !stop_i)
      take = (state == CAPTURE) || ((state == ARMED) && trig_ok);
    is_repeat = (count_o != '0) && (pc_i == last_pc);
    wr_en     = take && !is_repeat;
    rd_addr   = wrapped_o ? (wr_ptr + rd_idx_i) : rd_idx_i;
    rd_hit    = rd_en_i && ({1'b0, rd_idx_i} < count_o);
  end

  // NOTE: storage has no reset; count_o gates every read, so stale contents never leak out.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_pc[wr_ptr]  <= pc_i;
      mem_aux[wr_ptr] <= aux_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      count_o    <= '0;
      wr_ptr     <= '0;
      rep_cnt    <= '0;
      wrapped_o  <= 1'b0;
      halted_o   <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_pc_o    <= '0;
      rd_aux_o   <= '0;
      mode_q     <= 1'b0;
      trig_en_q  <= 1'b0;
      trig_pc_q  <= '0;
      last_pc    <= '0;
    end else begin
      // Reads see pre-edge memory, so a same-cycle write to that entry returns old data.
      rd_valid_o <= rd_hit;
      if (rd_hit) begin
        rd_pc_o  <= mem_pc[rd_addr];
        rd_aux_o <= mem_aux[rd_addr];
      end

      unique case (state)
        IDLE, DONE: begin
          if (arm_i) begin
            state     <= ARMED;
            count_o   <= '0;
            wr_ptr    <= '0;
            rep_cnt   <= '0;
            wrapped_o <= 1'b0;
            halted_o  <= 1'b0;
            mode_q    <= mode_i;
            trig_en_q <= trig_en_i;
            trig_pc_q <= trig_pc_i;
          end
        end
        ARMED: begin
          if (stop_i)
            state <= DONE;
          else if (take)
            state <= CAPTURE;
        end
        CAPTURE: begin
          if (stop_i)
            state <= DONE;
        end
      endcase

      if (take && is_repeat) begin
        rep_cnt <= rep_cnt + RW'(1);
        if (rep_cnt == RW'(HALT_CYC - 1)) begin
          state    <= DONE;
          halted_o <= 1'b1;
        end
      end

      // Later assignments override the case above: a filling write ends capture.
      if (wr_en) begin
        wr_ptr  <= wr_ptr + AW'(1);
        rep_cnt <= '0;
        last_pc <= pc_i;
        if (count_o == CW'(DEPTH))
          wrapped_o <= 1'b1;
        else
          count_o <= count_o + CW'(1);
        if (!mode_q && (count_o == CW'(DEPTH - 1)))
          state <= DONE;
      end
    end
  end

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Self-checking bench for pc_trace_buffer: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_pc_trace_buffer;

  localparam int PC_W     = 32;
  localparam int AUX_W    = 32;
  localparam int DEPTH    = 8;
  localparam int HALT_CYC = 4;
  localparam int AW       = 3;

  logic             clk_i = 1'b0;
  logic             rst_i, arm_i, stop_i, mode_i, trig_en_i, pc_valid_i, rd_en_i;
  logic [PC_W-1:0]  trig_pc_i, pc_i;
  logic [AUX_W-1:0] aux_i;
  logic [AW-1:0]    rd_idx_i;
  logic             rd_valid_o, wrapped_o, halted_o;
  logic [PC_W-1:0]  rd_pc_o;
  logic [AUX_W-1:0] rd_aux_o;
  logic [1:0]       state_o;
  logic [AW:0]      count_o;

  always #5 clk_i = ~clk_i;

  pc_trace_buffer #(
    .PC_W(PC_W), .AUX_W(AUX_W), .DEPTH(DEPTH), .HALT_CYC(HALT_CYC)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .arm_i(arm_i), .stop_i(stop_i),
    .mode_i(mode_i), .trig_en_i(trig_en_i), .trig_pc_i(trig_pc_i),
    .pc_valid_i(pc_valid_i), .pc_i(pc_i), .aux_i(aux_i),
    .rd_en_i(rd_en_i), .rd_idx_i(rd_idx_i),
    .rd_valid_o(rd_valid_o), .rd_pc_o(rd_pc_o), .rd_aux_o(rd_aux_o),
    .state_o(state_o), .count_o(count_o),
    .wrapped_o(wrapped_o), .halted_o(halted_o)
  );

  typedef struct {
    logic        rst;
    logic        arm;
    logic        stop;
    logic        mode;
    logic        trig_en;
    logic [31:0] trig_pc;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] aux;
    logic        rd_en;
    logic [2:0]  idx;
  } in_t;

  typedef struct {
    in_t         in;
    int          exp_state;
    int          exp_count;
    bit          exp_rdv;
    logic [31:0] exp_rdpc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] aux;
  } ent_t;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Reference model: the queue holds stored entries oldest-first.
  ent_t        q[$];
  int          m_state = 0;
  int          m_rep = 0;
  bit          m_wrapped = 0, m_halted = 0, m_mode = 0, m_trig_en = 0;
  logic [31:0] m_trig_pc = '0;
  bit          m_rdv = 0;
  logic [31:0] m_rdpc = '0, m_rdaux = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic void push(input ent_t e);
    if (q.size() == DEPTH) begin
      void'(q.pop_front());
      m_wrapped = 1;
    end
    q.push_back(e);
    m_rep = 0;
    if (!m_mode && q.size() == DEPTH) m_state = 3;
  endfunction

  function automatic void model_step(input in_t v);
    ent_t e;
    if (!v.rst) begin
      m_state = 0; q.delete(); m_wrapped = 0; m_halted = 0; m_rep = 0;
      m_rdv = 0; m_rdpc = '0; m_rdaux = '0;
      return;
    end
    m_rdv = v.rd_en && (int'(v.idx) < q.size());
    if (m_rdv) begin
      m_rdpc  = q[v.idx].pc;
      m_rdaux = q[v.idx].aux;
    end
    e.pc  = v.pc;
    e.aux = v.aux;
    case (m_state)
      0, 3: if (v.arm) begin
        m_state = 1; q.delete(); m_wrapped = 0; m_halted = 0; m_rep = 0;
        m_mode = v.mode; m_trig_en = v.trig_en; m_trig_pc = v.trig_pc;
      end
      1: if (v.stop) m_state = 3;
         else if (v.valid && (!m_trig_en || v.pc == m_trig_pc)) begin
           m_state = 2;
           push(e);
         end
      2: if (v.stop) m_state = 3;
         else if (v.valid) begin
           if (q.size() > 0 && v.pc == q[$].pc) begin
             m_rep++;
             if (m_rep == HALT_CYC) begin
               m_state  = 3;
               m_halted = 1;
             end
           end else begin
             push(e);
           end
         end
      default: ;
    endcase
  endfunction

  function automatic in_t idle();
    in_t v;
    v.rst = 1; v.arm = 0; v.stop = 0; v.mode = 0; v.trig_en = 0; v.trig_pc = '0;
    v.valid = 0; v.pc = '0; v.aux = '0; v.rd_en = 0; v.idx = '0;
    return v;
  endfunction

  function automatic in_t smp(input logic [31:0] pc);
    in_t v;
    v = idle();
    v.valid = 1; v.pc = pc; v.aux = pc ^ 32'hDEAD_0000;
    return v;
  endfunction

  task automatic step(input in_t v);
    rst_i = v.rst; arm_i = v.arm; stop_i = v.stop; mode_i = v.mode;
    trig_en_i = v.trig_en; trig_pc_i = v.trig_pc; pc_valid_i = v.valid;
    pc_i = v.pc; aux_i = v.aux; rd_en_i = v.rd_en; rd_idx_i = v.idx;
    model_step(v);
    @(posedge clk_i);
    #1;
    cyc++;
    check("state", 64'(state_o), 64'(m_state));
    check("count", 64'(count_o), 64'(q.size()));
    check("wrapped", 64'(wrapped_o), 64'(m_wrapped));
    check("halted", 64'(halted_o), 64'(m_halted));
    check("rd_valid", 64'(rd_valid_o), 64'(m_rdv));
    check("rd_pc", 64'(rd_pc_o), 64'(m_rdpc));
    check("rd_aux", 64'(rd_aux_o), 64'(m_rdaux));
  endtask

  task automatic arm_with(input logic mode, input logic trig_en, input logic [31:0] trig_pc);
    in_t v;
    v = idle(); v.arm = 1; v.mode = mode; v.trig_en = trig_en; v.trig_pc = trig_pc;
    step(v);
  endtask

  task automatic rd(input int idx);
    in_t v;
    v = idle(); v.rd_en = 1; v.idx = 3'(idx);
    step(v);
  endtask

  vec_t tab[11];

  initial begin
    in_t         v;
    logic [31:0] last;

    // Mode-0 fill: eight distinct PCs end capture, then read back entry 3.
    v = idle(); v.arm = 1;
    tab[0] = '{v, 1, 0, 0, 32'h0};
    for (int i = 0; i < 8; i++)
      tab[i + 1] = '{smp(32'(i * 4)), (i == 7) ? 3 : 2, i + 1, 0, 32'h0};
    v = idle(); v.rd_en = 1; v.idx = 3'd3;
    tab[9]  = '{v, 3, 8, 1, 32'h0C};
    tab[10] = '{idle(), 3, 8, 0, 32'h0};

    // Reset held with arm and a valid sample present.
    v = smp(32'h1234); v.rst = 0; v.arm = 1;
    step(v);
    step(v);
    rd(0);
    step(idle());
    check("rst_state", 64'(state_o), 64'd0);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_rdv", 64'(rd_valid_o), 64'd0);

    for (int i = 0; i < 11; i++) begin
      step(tab[i].in);
      check($sformatf("tab%0d_state", i), 64'(state_o), 64'(tab[i].exp_state));
      check($sformatf("tab%0d_count", i), 64'(count_o), 64'(tab[i].exp_count));
      check($sformatf("tab%0d_rdv", i), 64'(rd_valid_o), 64'(tab[i].exp_rdv));
      if (tab[i].exp_rdv)
        check($sformatf("tab%0d_rdpc", i), 64'(rd_pc_o), 64'(tab[i].exp_rdpc));
    end
    check("fill_halted", 64'(halted_o), 64'd0);

    // Wrap mode with a self-loop ending the run.
    arm_with(1, 0, 32'h0);
    for (int i = 0; i < 12; i++) step(smp(32'(i * 4)));
    for (int i = 0; i < 4; i++) step(smp(32'h2C));
    check("wrap_state", 64'(state_o), 64'd3);
    check("wrap_halted", 64'(halted_o), 64'd1);
    check("wrap_wrapped", 64'(wrapped_o), 64'd1);
    check("wrap_count", 64'(count_o), 64'd8);
    rd(0);
    check("wrap_idx0", 64'(rd_pc_o), 64'h10);
    rd(7);
    check("wrap_idx7", 64'(rd_pc_o), 64'h2C);

    // Trigger: samples before the trigger PC are discarded.
    arm_with(0, 1, 32'h40);
    step(smp(32'h38));
    step(smp(32'h3C));
    check("trig_wait_state", 64'(state_o), 64'd1);
    check("trig_wait_count", 64'(count_o), 64'd0);
    step(smp(32'h40));
    step(smp(32'h44));
    check("trig_count", 64'(count_o), 64'd2);
    v = smp(32'h48); v.stop = 1;
    step(v);
    check("trig_stop_state", 64'(state_o), 64'd3);
    check("trig_stop_halted", 64'(halted_o), 64'd0);
    check("trig_stop_count", 64'(count_o), 64'd2);
    rd(2);
    check("trig_rd2_valid", 64'(rd_valid_o), 64'd0);
    rd(0);
    check("trig_rd0_pc", 64'(rd_pc_o), 64'h40);

    // Reset mid-capture, then restart.
    arm_with(1, 0, 32'h0);
    for (int i = 0; i < 5; i++) step(smp(32'h200 + 32'(i * 4)));
    check("mid_count", 64'(count_o), 64'd5);
    v = idle(); v.rst = 0;
    step(v);
    check("mid_rst_state", 64'(state_o), 64'd0);
    check("mid_rst_count", 64'(count_o), 64'd0);
    arm_with(0, 0, 32'h0);
    step(smp(32'h100));
    check("restart_count", 64'(count_o), 64'd1);
    rd(0);
    check("restart_pc", 64'(rd_pc_o), 64'h100);

    // arm ignored in CAPTURE; stop beats arm in ARMED.
    v = smp(32'h104); v.arm = 1;
    step(v);
    check("arm_cap_state", 64'(state_o), 64'd2);
    check("arm_cap_count", 64'(count_o), 64'd2);
    v = idle(); v.stop = 1;
    step(v);
    arm_with(0, 0, 32'h0);
    v = smp(32'h300); v.arm = 1; v.stop = 1;
    step(v);
    check("armstop_state", 64'(state_o), 64'd3);
    check("armstop_count", 64'(count_o), 64'd0);

    // Randomized traffic against the model.
    last = '0;
    for (int n = 0; n < 3000; n++) begin
      v = idle();
      v.rst     = ($urandom_range(0, 199) != 0);
      v.arm     = ($urandom_range(0, 29) == 0);
      v.stop    = ($urandom_range(0, 59) == 0);
      v.mode    = 1'($urandom_range(0, 1));
      v.trig_en = 1'($urandom_range(0, 1));
      v.trig_pc = 32'(4 * $urandom_range(0, 7));
      v.valid   = ($urandom_range(0, 9) < 7);
      v.pc      = ($urandom_range(0, 1) == 0) ? last : 32'(4 * $urandom_range(0, 7));
      v.aux     = 32'($urandom);
      v.rd_en   = 1'($urandom_range(0, 1));
      v.idx     = 3'($urandom_range(0, 7));
      last = v.pc;
      step(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
